// File: rtl/lau_rr_scheduler.sv
// Round-robin scheduler sharing one combinational LAU among NREQ requesters, with a registered operand stage.
// Latency: rsp_valid rises LAT+1 cycles after the grant edge (1 cycle for a zero-operand mul/div when bypass is built in).
// Backpressure: the response is held until rsp_ready; no new grant is issued until the block is back in IDLE.
// Build option: define LAU_ZERO_BYPASS_EN to answer mul/div with a zero operand directly, without waiting on the LAU.
module lau_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int LAT  = 1,
    parameter int IDW  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [2*NREQ-1:0]      req_op,
    input  logic [NREQ-1:0]        req_sx,
    input  logic [NREQ-1:0]        req_sy,
    input  logic [16*NREQ-1:0]     req_lx,
    input  logic [16*NREQ-1:0]     req_ly,
    input  logic [15:0]            cfg_lm,
    output logic [1:0]             lau_op,
    output logic                   lau_sx,
    output logic                   lau_sy,
    output logic [15:0]            lau_lx,
    output logic [15:0]            lau_ly,
    output logic [15:0]            lau_lm,
    input  logic                   lau_sz,
    input  logic [15:0]            lau_lz,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic                   rsp_sz,
    output logic [15:0]            rsp_lz,
    output logic                   busy
);

    localparam logic [15:0] LNS_ZERO = 16'hFF1C;
    localparam logic [3:0]  LAT_CNT  = 4'(LAT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q;
    logic [3:0]      cnt_q;
    logic [IDW-1:0]  id_q;
    logic [1:0]      op_q;
    logic            sx_q, sy_q;
    logic [15:0]     lx_q, ly_q, lm_q;
    logic            rsp_valid_q, rsp_sz_q;
    logic [15:0]     rsp_lz_q;

    logic            hi_any, lo_any, gnt_any;
    logic [IDW-1:0]  hi_idx, lo_idx, gnt_idx;
    logic [NREQ-1:0] gnt_onehot;
    logic [1:0]      sel_op;
    logic            sel_sx, sel_sy;
    logic [15:0]     sel_lx, sel_ly;
    logic            bypass;

    // Round-robin search: lowest valid index above the pointer, else lowest valid index at or below it
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (i > int'(ptr_q)) begin
                    hi_any = 1'b1;
                    hi_idx = IDW'(i);
                end else begin
                    lo_any = 1'b1;
                    lo_idx = IDW'(i);
                end
            end
        end
        gnt_any = hi_any | lo_any;
        gnt_idx = hi_any ? hi_idx : lo_idx;
    end

    // Operand mux for the winning requester
    always_comb begin
        gnt_onehot = '0;
        sel_op     = '0;
        sel_sx     = 1'b0;
        sel_sy     = 1'b0;
        sel_lx     = '0;
        sel_ly     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gnt_idx) begin
                gnt_onehot[i] = 1'b1;
                sel_op        = req_op[2*i +: 2];
                sel_sx        = req_sx[i];
                sel_sy        = req_sy[i];
                sel_lx        = req_lx[16*i +: 16];
                sel_ly        = req_ly[16*i +: 16];
            end
        end
    end

`ifdef LAU_ZERO_BYPASS_EN
    // A zero operand makes any product or quotient zero, so the LAU result is not needed
    assign bypass = sel_op[1] && ((sel_lx == LNS_ZERO) || (sel_ly == LNS_ZERO));
`else
    assign bypass = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (gnt_any) state_d = bypass ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt_q == 4'd1) state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: grant only while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == S_IDLE) && gnt_any) req_ready = gnt_onehot;
        busy = (state_q != S_IDLE);
    end

    // Operand, pointer, settle counter and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= IDW'(NREQ - 1);
            cnt_q       <= '0;
            id_q        <= '0;
            op_q        <= '0;
            sx_q        <= 1'b0;
            sy_q        <= 1'b0;
            lx_q        <= '0;
            ly_q        <= '0;
            lm_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sz_q    <= 1'b0;
            rsp_lz_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_any) begin
                        op_q  <= sel_op;
                        sx_q  <= sel_sx;
                        sy_q  <= sel_sy;
                        lx_q  <= sel_lx;
                        ly_q  <= sel_ly;
                        lm_q  <= cfg_lm;
                        id_q  <= gnt_idx;
                        ptr_q <= gnt_idx;
                        cnt_q <= LAT_CNT;
                        if (bypass) begin
                            rsp_sz_q    <= 1'b0;
                            rsp_lz_q    <= LNS_ZERO;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        rsp_sz_q    <= lau_sz;
                        rsp_lz_q    <= lau_lz;
                        rsp_valid_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) rsp_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign lau_op    = op_q;
    assign lau_sx    = sx_q;
    assign lau_sy    = sy_q;
    assign lau_lx    = lx_q;
    assign lau_ly    = ly_q;
    assign lau_lm    = lm_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_sz    = rsp_sz_q;
    assign rsp_lz    = rsp_lz_q;

endmodule

// File: tb/tb_lau_rr_scheduler.sv
// Bench for lau_rr_scheduler: table of grant vectors plus hand-written backpressure, reset and rotation sequences.
// A behavioural LAU is attached; expected responses are queued at grant and compared when rsp_valid rises.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_lau_rr_scheduler;

    localparam int NREQ = 4;
    localparam int LAT  = 1;
    localparam int IDW  = 2;
    localparam logic [15:0] ZERO = 16'hFF1C;
`ifdef LAU_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk, rst_n;
    logic [NREQ-1:0]      req_valid, req_ready, req_sx, req_sy;
    logic [2*NREQ-1:0]    req_op;
    logic [16*NREQ-1:0]   req_lx, req_ly;
    logic [15:0]          cfg_lm;
    logic [1:0]           lau_op;
    logic                 lau_sx, lau_sy, lau_sz;
    logic [15:0]          lau_lx, lau_ly, lau_lm, lau_lz;
    logic                 rsp_valid, rsp_ready, rsp_sz, busy;
    logic [IDW-1:0]       rsp_id;
    logic [15:0]          rsp_lz;

    lau_rr_scheduler #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_sx(req_sx), .req_sy(req_sy), .req_lx(req_lx), .req_ly(req_ly),
        .cfg_lm(cfg_lm),
        .lau_op(lau_op), .lau_sx(lau_sx), .lau_sy(lau_sy),
        .lau_lx(lau_lx), .lau_ly(lau_ly), .lau_lm(lau_lm),
        .lau_sz(lau_sz), .lau_lz(lau_lz),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sz(rsp_sz), .rsp_lz(rsp_lz), .busy(busy)
    );

    // Behavioural LAU: exact log-domain mul/div; add/sub are deterministic stand-ins
    function automatic logic [16:0] lau_fn(input logic [1:0] op, input logic sx, input logic sy,
                                           input logic [15:0] lx, input logic [15:0] ly, input logic [15:0] lm);
        case (op)
            2'b10:   return {sx ^ sy, lx + ly - lm};
            2'b11:   return {sx ^ sy, lx - ly + lm};
            2'b00:   return {sx, lx ^ ly};
            default: return {~sx, lx ^ ~ly};
        endcase
    endfunction

    always_comb {lau_sz, lau_lz} = lau_fn(lau_op, lau_sx, lau_sy, lau_lx, lau_ly, lau_lm);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [IDW-1:0] id;
        logic           sz;
        logic [15:0]    lz;
        int             lat;
        int             gcyc;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [NREQ-1:0] vld;
        logic [1:0]      op;
        logic            sx, sy;
        logic [15:0]     lx, ly, lm;
        int              exp_g;
    } vec_t;
    vec_t vecs[$];

    int checks = 0, failures = 0, rises = 0;
    logic rsp_prev = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    // One falling edge: scoreboard push on grant, pop and compare on response rise
    task automatic tick();
        int g, n;
        logic [1:0] op;
        logic sx, sy;
        logic [15:0] lx, ly;
        logic [16:0] r;
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            rsp_prev = 1'b0;
            return;
        end
        if (req_ready != '0) begin
            g = 0; n = 0; op = '0; sx = 0; sy = 0; lx = '0; ly = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    g = i; n++;
                    op = req_op[2*i +: 2]; sx = req_sx[i]; sy = req_sy[i];
                    lx = req_lx[16*i +: 16]; ly = req_ly[16*i +: 16];
                end
            end
            chk("ready_onehot", 64'(n), 64'd1);
            chk("ready_without_valid", 64'(req_ready & ~req_valid), 64'd0);
            e.id = IDW'(g);
            e.gcyc = cyc;
            if (BYP && op[1] && (lx == ZERO || ly == ZERO)) begin
                e.sz = 1'b0; e.lz = ZERO; e.lat = 1;
            end else begin
                r = lau_fn(op, sx, sy, lx, ly, cfg_lm);
                e.sz = r[16]; e.lz = r[15:0]; e.lat = LAT + 1;
            end
            sbq.push_back(e);
        end
        if (rsp_valid && !rsp_prev) begin
            rises++;
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("rsp_id", 64'(rsp_id), 64'(e.id));
                chk("rsp_sz", 64'(rsp_sz), 64'(e.sz));
                chk("rsp_lz", 64'(rsp_lz), 64'(e.lz));
                chk("rsp_latency", 64'(cyc - e.gcyc), 64'(e.lat));
            end
        end
        rsp_prev = rsp_valid;
    endtask

    task automatic wait_grant(output int g, output bit ok);
        g = -1; ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (!busy && !rsp_valid) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic drive_junk();
        for (int i = 0; i < NREQ; i++) begin
            req_op[2*i +: 2]   = 2'(i);
            req_sx[i]          = i[0];
            req_sy[i]          = 1'b1;
            req_lx[16*i +: 16] = 16'(16'h1000 * (i + 1) + 16'h0123);
            req_ly[16*i +: 16] = 16'(16'h0211 * (i + 1));
        end
        cfg_lm = 16'h0155;
    endtask

    task automatic drive_vec(input vec_t v);
        drive_junk();
        req_op[2*v.exp_g +: 2]   = v.op;
        req_sx[v.exp_g]          = v.sx;
        req_sy[v.exp_g]          = v.sy;
        req_lx[16*v.exp_g +: 16] = v.lx;
        req_ly[16*v.exp_g +: 16] = v.ly;
        cfg_lm                   = v.lm;
        req_valid                = v.vld;
    endtask

    function automatic vec_t mk(input logic [3:0] vld, input logic [1:0] op, input logic sx, input logic sy,
                                input logic [15:0] lx, input logic [15:0] ly, input logic [15:0] lm, input int g);
        vec_t v;
        v.vld = vld; v.op = op; v.sx = sx; v.sy = sy; v.lx = lx; v.ly = ly; v.lm = lm; v.exp_g = g;
        return v;
    endfunction

    initial begin
        int g, prev_g;
        bit ok;
        int r0;
        logic [IDW+16:0] snap;

        vecs.push_back(mk(4'b0001, 2'b10, 1, 0, 16'h0400, 16'h0400, 16'h0000, 0));
        vecs.push_back(mk(4'b0010, 2'b10, 0, 0, 16'h0123, 16'h0200, 16'h0100, 1));
        vecs.push_back(mk(4'b1010, 2'b11, 1, 1, 16'h0800, 16'h0300, 16'h0400, 3));
        vecs.push_back(mk(4'b1010, 2'b10, 0, 1, 16'h7000, 16'h0010, 16'h0020, 1));
        vecs.push_back(mk(4'b1000, 2'b00, 1, 0, 16'h1234, 16'h00FF, 16'h0000, 3));
        vecs.push_back(mk(4'b1000, 2'b01, 0, 1, 16'h4321, 16'h0F0F, 16'h0000, 3));
        vecs.push_back(mk(4'b1111, 2'b10, 1, 1, 16'hFFFF, 16'h0001, 16'h0400, 0));
        vecs.push_back(mk(4'b1101, 2'b11, 0, 1, 16'h0000, 16'h0001, 16'h0002, 2));
        vecs.push_back(mk(4'b0101, 2'b10, 1, 0, 16'h8000, 16'h8000, 16'h0400, 0));
        vecs.push_back(mk(4'b0110, 2'b00, 0, 0, 16'hA5A5, 16'h5A5A, 16'h0000, 1));
        vecs.push_back(mk(4'b0100, 2'b01, 1, 1, 16'h3C3C, 16'h0001, 16'h0000, 2));
        vecs.push_back(mk(4'b0100, 2'b11, 1, 0, ZERO,     16'h0300, 16'h0400, 2));
        vecs.push_back(mk(4'b0011, 2'b10, 1, 1, 16'h0500, ZERO,     16'h0400, 0));
        vecs.push_back(mk(4'b0001, 2'b00, 1, 0, ZERO,     16'h0100, 16'h0400, 0));

        // Reset state, with requests pending to show that req_ready stays low in reset
        rst_n = 1'b0; rsp_ready = 1'b1; drive_junk(); req_valid = 4'hF;
        #3;
        chk("reset_outputs", 64'({lau_op, lau_sx, lau_sy, lau_lx, lau_ly, lau_lm, rsp_valid, rsp_id, rsp_sz, rsp_lz}), 64'd0);
        chk("reset_ready_busy", 64'({req_ready, busy}), 64'd0);
        req_valid = '0;
        #9 rst_n = 1'b1;

        // Table-driven grants; operands and cfg_lm are scrambled right after each grant edge
        foreach (vecs[k]) begin
            at_edge();
            drive_vec(vecs[k]);
            wait_grant(g, ok);
            chk("grant_seen", 64'(ok), 64'd1);
            chk("grant_idx", 64'(g), 64'(vecs[k].exp_g));
            at_edge();
            req_valid = '0; cfg_lm = ~cfg_lm; req_lx = ~req_lx; req_ly = ~req_ly;
            wait_idle(ok);
            chk("idle_after_rsp", 64'(ok), 64'd1);
            chk("lau_lx_retained", 64'(lau_lx), 64'(vecs[k].lx));
        end

        // Backpressure: response held for 5 cycles, no grant meanwhile, next grant right after accept
        at_edge();
        rsp_ready = 1'b0; drive_junk(); req_valid = 4'b0100;
        wait_grant(g, ok);
        chk("bp_grant", 64'(g), 64'd2);
        at_edge();
        req_valid = 4'b1011;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            tick();
            ok = rsp_valid;
        end
        chk("bp_rsp_seen", 64'(ok), 64'd1);
        snap = {rsp_id, rsp_sz, rsp_lz};
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("bp_rsp_hold", 64'({rsp_valid, rsp_id, rsp_sz, rsp_lz}), 64'({1'b1, snap}));
            chk("bp_no_ready", 64'(req_ready), 64'd0);
        end
        at_edge();
        rsp_ready = 1'b1;
        tick();
        chk("bp_no_grant_same_cycle", 64'(req_ready), 64'd0);
        tick();
        chk("bp_grant_after_accept", 64'(req_ready), 64'b1000);
        at_edge();
        req_valid = '0;
        wait_idle(ok);
        chk("bp_idle", 64'(ok), 64'd1);

        // Reset during WAIT: outputs clear at once, in-flight op is dropped, pointer restarts
        at_edge();
        drive_junk(); req_valid = 4'b0010;
        wait_grant(g, ok);
        chk("rst_grant", 64'(g), 64'd1);
        at_edge();
        req_valid = '0;
        tick();
        chk("rst_in_wait", 64'({busy, rsp_valid}), 64'b10);
        #1 rst_n = 1'b0; req_valid = 4'hF;
        #1;
        chk("rst_mid_outputs", 64'({lau_op, lau_sx, lau_sy, lau_lx, lau_ly, lau_lm, rsp_valid, rsp_id, rsp_sz, rsp_lz}), 64'd0);
        chk("rst_mid_ready_busy", 64'({req_ready, busy}), 64'd0);
        sbq.delete();
        r0 = rises;
        tick();
        tick();
        req_valid = '0;
        #1 rst_n = 1'b1;
        for (int n = 0; n < 6; n++) tick();
        chk("rst_no_rsp", 64'(rises), 64'(r0));
        chk("rst_not_busy", 64'(busy), 64'd0);

        // All requesters continuously valid: rotation 0,1,2,3,0 at LAT+2 spacing
        at_edge();
        for (int i = 0; i < NREQ; i++) begin
            req_op[2*i +: 2]   = 2'b10;
            req_sx[i]          = i[1];
            req_sy[i]          = 1'b0;
            req_lx[16*i +: 16] = 16'(16'h0100 * (i + 1));
            req_ly[16*i +: 16] = 16'(16'h0040 * (i + 1));
        end
        cfg_lm = 16'h0200;
        req_valid = 4'hF;
        prev_g = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g, ok);
            chk("rr_order", 64'(g), 64'(k % NREQ));
            if (k > 0) chk("rr_spacing", 64'(cyc - prev_g), 64'(LAT + 2));
            prev_g = cyc;
        end
        at_edge();
        req_valid = '0;
        wait_idle(ok);
        chk("rr_idle", 64'(ok), 64'd1);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lau_rr_scheduler.md
Name: lau_rr_scheduler

Overview:
Shares a single combinational LAU datapath (16-bit LNS, 6.10 fixed-point log, zero code 0xFF1C) among NREQ requesters. Round-robin arbitration, valid/ready request handshake, operand registering, fixed settle delay of LAT cycles, and one shared response channel carrying the requester ID. Sits between the LNS client blocks and the LAU instance. Also holds the multiply/divide bias Lm as a configuration input.

Parameters:
NREQ, 4, number of requesters (2..8)
LAT, 1, cycles the LAU outputs are allowed to settle after operands are registered (1..15)
IDW, 2, width of rsp_id; must be >= clog2(NREQ)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_op  in  2*NREQ  op per requester: 00 add, 01 sub, 10 mul, 11 div; slice i = [2i+1:2i]
req_sx  in  NREQ  operand X sign
req_sy  in  NREQ  operand Y sign
req_lx  in  16*NREQ  operand X log magnitude; slice i = [16i+15:16i]
req_ly  in  16*NREQ  operand Y log magnitude
cfg_lm  in  16  bias Lm forwarded to LAU; sampled at grant
lau_op  out  2  registered op to LAU
lau_sx  out  1  registered Sx
lau_sy  out  1  registered Sy
lau_lx  out  16  registered Lx
lau_ly  out  16  registered Ly
lau_lm  out  16  registered Lm
lau_sz  in  1  LAU result sign
lau_lz  in  16  LAU result log magnitude
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accept
rsp_id  out  IDW  index of requester owning the result
rsp_sz  out  1  result sign
rsp_lz  out  16  result log magnitude
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE, rr pointer=NREQ-1, all lau_* and rsp_* registers 0, rsp_valid=0, req_ready=0, busy=0, settle counter 0. Reset mid-operation discards the in-flight op; no response is produced.
- Arbitration: in IDLE only. Winner g = first i with req_valid[i]=1, searching pointer+1, pointer+2, ... modulo NREQ. req_ready[g]=1 combinationally in that cycle; the handshake completes on that edge. The pointer then becomes g.
- The search is purely combinational on req_valid. Requesters hold valid and operands stable until ready. Dropping valid before ready is legal and simply withdraws the request.
- States:
  - IDLE: no valid -> stay. Any valid -> latch req_op/sx/sy/lx/ly[g] and cfg_lm into lau_*, latch g into id register, set counter=LAT, go WAIT.
  - WAIT: counter decrements each cycle. When counter==1, capture lau_sz/lau_lz into rsp_sz/rsp_lz, set rsp_valid=1, go RESP.
  - RESP: hold rsp_* stable. When rsp_ready=1, clear rsp_valid and go IDLE.
- Timing: grant edge = cycle 0. rsp_valid rises at cycle LAT+1. Minimum issue interval is LAT+2 cycles: rsp_ready tied high and requests always pending.
- No grant is issued in WAIT or RESP, even if rsp_ready is high in the same cycle; the next grant is evaluated in the following IDLE cycle.
- lau_* registers keep their last value outside WAIT; they are not cleared after use.
- Width: no arithmetic in this block other than the counter (4 bits) and the modulo-NREQ pointer increment (wraps NREQ-1 -> 0).
- Single requester continuously valid: granted every issue slot (no starvation of others, since rotation resumes whenever others assert).

Optional Feature:
LAU_ZERO_BYPASS_EN:
- Defined: in IDLE, if the granted op is mul/div (op[1]=1) and lx or ly equals 0xFF1C, skip WAIT. rsp_lz=0xFF1C, rsp_sz=0, rsp_valid=1 at cycle 1, state goes directly to RESP. lau_* registers are still updated.
- Not defined: every op goes through WAIT with full LAT latency.

Test Plan:
- Single mul, LAT=1, req 0: op=10, Lx=0x0400, Ly=0x0400, Sx=1, Sy=0, cfg_lm=0, real LAU attached -> req_ready[0] at cycle 0; rsp_valid at cycle 2 with rsp_id=0, rsp_lz=0x0800, rsp_sz=1.
- All four requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0; issues spaced exactly LAT+2 cycles apart; rsp_id matches the grant order.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable and no req_ready asserted. Release -> next grant one cycle after the accept.
- Requesters 1 and 3 valid, pointer=1 -> grant 3 first, then 1. Requester 3 alone afterwards -> granted again, pointer wraps 3 -> 0 search.
- rst_n pulsed low during WAIT -> all outputs 0 immediately; no rsp_valid after release; the next request is served normally with pointer=NREQ-1 (grant to 0 first).
- With LAU_ZERO_BYPASS_EN, div with Lx=0xFF1C -> rsp_valid at cycle 1, rsp_lz=0xFF1C, rsp_sz=0. Without the macro -> rsp_valid at cycle LAT+1.
